wb_trace_fifo: RTL and testbench

Write-back trace buffer sitting directly downstream of the `mips` single-cycle core in simulation and bring-up builds. Each cycle it captures the core's architectural write events (GRF writes and data-memory stores), tags each with the committing PC, and queues them in a FIFO. Entries are drained to a trace checker or printer through a valid/ready handshake. The buffer decouples the core, which never stalls, from a slower consumer, and flags any lost events.

---
 rtl/wb_trace_fifo.sv | 62 ++++++
 tb/tb_wb_trace_fifo.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: captures GRF/DM write events tagged with PC into a show-ahead FIFO with sticky overflow
module wb_trace_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              pc,
  input  logic                     grf_we,
  input  logic [4:0]               grf_addr,
  input  logic [31:0]              grf_wd,
  input  logic                     dm_we,
  input  logic [31:0]              dm_addr,
  input  logic [31:0]              dm_wd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_kind,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_addr,
  output logic [31:0]              out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [96:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] free;
  logic          g, d, acc_g, acc_d, pop;
  logic [96:0]   grf_e, dm_e;
  // Space is judged on start-of-cycle occupancy; a same-cycle pop never frees room for pushes.
  always_comb begin
    free  = CW'(DEPTH) - count;
    g     = grf_we && grf_addr != 5'd0;
    d     = dm_we;
    acc_g = g && |free;
    acc_d = d && (g ? |free[CW-1:1] : |free);
    pop   = out_valid && out_ready;
    grf_e = {1'b0, pc, 27'd0, grf_addr, grf_wd};
    dm_e  = {1'b1, pc, dm_addr, dm_wd};
  end
  assign out_valid = |count;
  assign {out_kind, out_pc, out_addr, out_data} = out_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(acc_g) + AW'(acc_d);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + CW'(acc_g) + CW'(acc_d) - CW'(pop);
      overflow <= overflow | (g && !acc_g) | (d && !acc_d);
    end
  end
  // GRF entry is always the older one when both events land in the same cycle.
  always_ff @(posedge clk) begin
    if (acc_g) mem[wr_ptr] <= grf_e;
    else if (acc_d) mem[wr_ptr] <= dm_e;
    if (acc_g && acc_d) mem[wr_ptr + 1'b1] <= dm_e;
  end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: directed stimulus with a queue scoreboard checked by an independent pop monitor
module tb_wb_trace_fifo;
  logic        clk, reset;
  logic [31:0] pc, grf_wd, dm_addr, dm_wd;
  logic [4:0]  grf_addr;
  logic        grf_we, dm_we, out_ready;
  logic        out_valid, out_kind, overflow;
  logic [31:0] out_pc, out_addr, out_data;
  logic [3:0]  count;
  typedef struct {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;
  ent_t exp_q[$];
  int checks = 0;
  int errors = 0;
  wb_trace_fifo #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .pc(pc), .grf_we(grf_we), .grf_addr(grf_addr), .grf_wd(grf_wd),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .out_valid(out_valid), .out_ready(out_ready),
    .out_kind(out_kind), .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data),
    .count(count), .overflow(overflow)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask
  task automatic expect_ent(input logic kind, input logic [31:0] p, input logic [31:0] a, input logic [31:0] dt);
    ent_t e;
    e.kind = kind; e.pc = p; e.addr = a; e.data = dt;
    exp_q.push_back(e);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    grf_we = 0;
    dm_we  = 0;
  endtask
  task automatic set_grf(input logic [31:0] p, input logic [4:0] a, input logic [31:0] dt);
    pc = p; grf_we = 1; grf_addr = a; grf_wd = dt;
  endtask
  task automatic set_dm(input logic [31:0] a, input logic [31:0] dt);
    dm_we = 1; dm_addr = a; dm_wd = dt;
  endtask
  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (count == 0) break;
    end
    chk("drain_count", 32'(count), 0);
    out_ready = 0;
  endtask
  task automatic do_reset();
    reset = 1;
    exp_q.delete();
    out_ready = 0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask
  // Monitor: every accepted head entry must match the oldest expectation.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got data %0h expected no entry", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_kind", 32'(out_kind), 32'(e.kind));
          chk("pop_pc", out_pc, e.pc);
          chk("pop_addr", out_addr, e.addr);
          chk("pop_data", out_data, e.data);
        end
      end
    end
  end
  initial begin
    reset = 1;
    pc = $urandom; grf_we = 1; grf_addr = 5'($urandom_range(1, 31)); grf_wd = $urandom;
    dm_we = 1; dm_addr = $urandom; dm_wd = $urandom; out_ready = 1;
    #10;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_kind", 32'(out_kind), 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    grf_we = 0; dm_we = 0; out_ready = 0;
    @(posedge clk);
    #1;
    reset = 0;
    out_ready = 1;
    set_grf(32'h3000, 5'd8, 32'h1234);
    expect_ent(0, 32'h3000, 32'd8, 32'h1234);
    step();
    chk("single_valid", 32'(out_valid), 1);
    chk("single_count", 32'(count), 1);
    step();
    chk("single_count_after", 32'(count), 0);
    chk("single_valid_after", 32'(out_valid), 0);
    set_grf(32'h3004, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("zero_reg_count", 32'(count), 0);
    chk("zero_reg_valid", 32'(out_valid), 0);
    step();
    chk("zero_reg_valid2", 32'(out_valid), 0);
    out_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      set_grf(32'h3100 + 32'(4 * i), 5'(i), 32'(i));
      if (i <= 8) expect_ent(0, 32'h3100 + 32'(4 * i), 32'(i), 32'(i));
      step();
    end
    chk("fill_count", 32'(count), 8);
    chk("fill_overflow", 32'(overflow), 1);
    step();
    chk("hold_head_data", out_data, 1);
    chk("hold_head_addr", out_addr, 1);
    drain();
    chk("overflow_sticky", 32'(overflow), 1);
    do_reset();
    chk("reset_clears_overflow", 32'(overflow), 0);
    set_grf(32'h3004, 5'd3, 32'hA);
    set_dm(32'h10, 32'hB);
    expect_ent(0, 32'h3004, 32'd3, 32'hA);
    expect_ent(1, 32'h3004, 32'h10, 32'hB);
    step();
    chk("dual_count", 32'(count), 2);
    chk("dual_overflow", 32'(overflow), 0);
    for (int i = 0; i < 5; i++) begin
      set_grf(32'h3008 + 32'(4 * i), 5'd1, 32'h20 + 32'(i));
      expect_ent(0, 32'h3008 + 32'(4 * i), 32'd1, 32'h20 + 32'(i));
      step();
    end
    chk("seven_count", 32'(count), 7);
    set_grf(32'h3020, 5'd3, 32'hA);
    set_dm(32'h10, 32'hB);
    expect_ent(0, 32'h3020, 32'd3, 32'hA);
    step();
    chk("dual_one_free_count", 32'(count), 8);
    chk("dual_one_free_overflow", 32'(overflow), 1);
    drain();
    for (int i = 0; i < 5; i++) begin
      set_grf(32'h4000 + 32'(4 * i), 5'd2, 32'h90 + 32'(i));
      step();
    end
    chk("mid_count", 32'(count), 5);
    @(negedge clk);
    reset = 1;
    exp_q.delete();
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_data", out_data, 0);
    set_grf(32'h4100, 5'd9, 32'h77);
    @(posedge clk);
    #1;
    chk("rst_ignores_events", 32'(count), 0);
    grf_we = 0;
    reset = 0;
    set_grf(32'h5000, 5'd4, 32'h55);
    expect_ent(0, 32'h5000, 32'd4, 32'h55);
    step();
    chk("post_rst_count", 32'(count), 1);
    chk("post_rst_data", out_data, 32'h55);
    drain();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
